// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one Data Memory port between the I-cache (port 0)
// and the D-cache (port 1). The grant stays with the owner while its enable is held.
module dmem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_data_o,
    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [1:0]        grant_o,
    output logic              timeout_o
);

    localparam int unsigned     CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    state_t           state;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       grant;
    logic             timeout;
    logic             owner_en;
    logic             count_en;

    always_comb begin
        owner_en = 1'b0;
        case (state)
            OWN0:    owner_en = m0_enable_i;
            OWN1:    owner_en = m1_enable_i;
            default: owner_en = 1'b0;
        endcase
    end

    // Counter saturates at TIMEOUT so a long stall can never wrap it back to zero.
    assign count_en = (TIMEOUT != 0) && owner_en && !mem_ack_i && (cnt != CNT_MAX);
    assign cnt_inc  = cnt + 1'b1;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            last    <= 1'b1;
            cnt     <= '0;
            grant   <= '0;
            timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (m0_enable_i && (!m1_enable_i || last)) begin
                        state <= OWN0;
                        last  <= 1'b0;
                        grant <= 2'b01;
                    end else if (m1_enable_i) begin
                        state <= OWN1;
                        last  <= 1'b1;
                        grant <= 2'b10;
                    end
                end
                OWN0: begin
                    if (!m0_enable_i) begin
                        cnt <= '0;
                        if (m1_enable_i) begin
                            state <= OWN1;
                            last  <= 1'b1;
                            grant <= 2'b10;
                        end else begin
                            state <= IDLE;
                            grant <= '0;
                        end
                    end else if (mem_ack_i) begin
                        cnt <= '0;
                    end else if (count_en) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == CNT_MAX) timeout <= 1'b1;
                    end
                end
                OWN1: begin
                    if (!m1_enable_i) begin
                        cnt <= '0;
                        if (m0_enable_i) begin
                            state <= OWN0;
                            last  <= 1'b0;
                            grant <= 2'b01;
                        end else begin
                            state <= IDLE;
                            grant <= '0;
                        end
                    end else if (mem_ack_i) begin
                        cnt <= '0;
                    end else if (count_en) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == CNT_MAX) timeout <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        m0_ack_o     = 1'b0;
        m1_ack_o     = 1'b0;
        case (state)
            OWN0: begin
                mem_enable_o = m0_enable_i;
                mem_write_o  = m0_write_i;
                mem_addr_o   = m0_addr_i;
                mem_data_o   = m0_data_i;
                m0_ack_o     = mem_ack_i;
            end
            OWN1: begin
                mem_enable_o = m1_enable_i;
                mem_write_o  = m1_write_i;
                mem_addr_o   = m1_addr_i;
                mem_data_o   = m1_data_i;
                m1_ack_o     = mem_ack_i;
            end
            default: ;
        endcase
    end

    assign m0_data_o = mem_data_i;
    assign m1_data_o = mem_data_i;
    assign grant_o   = grant;
    assign timeout_o = timeout;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single 256-bit Data Memory between the instruction cache (port 0) and the data cache (port 1). It sits between the cache controllers' memory interfaces and the Data Memory. It grants ownership round-robin and holds the grant for as long as the owner keeps its enable asserted, so a dirty writeback followed by a refill completes without interruption. It routes the memory acknowledge only to the owner and flags a stuck transaction through a watchdog.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 256, cache line width.
- TIMEOUT, 255, cycles without ack before `timeout_o` sets; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- m0_enable_i, m1_enable_i  in  1  request / transaction in progress.
- m0_write_i, m1_write_i  in  1  1 = write, 0 = read.
- m0_addr_i, m1_addr_i  in  ADDR_W  line address.
- m0_data_i, m1_data_i  in  DATA_W  write data.
- m0_ack_o, m1_ack_o  out  1  memory ack forwarded to that port.
- m0_data_o, m1_data_o  out  DATA_W  read data.
- mem_enable_o  out  1  to Data Memory.
- mem_write_o  out  1  to Data Memory.
- mem_addr_o  out  ADDR_W  to Data Memory.
- mem_data_o  out  DATA_W  to Data Memory.
- mem_data_i  in  DATA_W  from Data Memory.
- mem_ack_i  in  1  from Data Memory.
- grant_o  out  2  one-hot owner; 00 when idle.
- timeout_o  out  1  sticky watchdog flag.

## Operation
- States: IDLE, OWN0, OWN1. Registered `last` pointer holds the most recently granted port.
- IDLE: all mem_* outputs are 0. At each edge:
  - Only one enable high: grant that port.
  - Both high: grant the port not equal to `last`.
  - Neither high: stay in IDLE.
  - On every grant, `last` is updated to the granted port.
- OWNx:
  - mem_enable_o, mem_write_o, mem_addr_o and mem_data_o mirror port x combinationally.
  - mx_ack_o = mem_ack_i; the other port's ack is 0.
- Grant is sticky while mx_enable_i = 1. An ack does not release the grant, and address/write may change between back-to-back transactions.
- Release: at an edge where mx_enable_i = 0:
  - If the other port's enable is high, go directly to the other OWN state and update `last`.
  - Otherwise go to IDLE.
- m0_data_o and m1_data_o are both driven with mem_data_i. The data is valid only in the cycle the port's ack is high.
- mem_ack_i in IDLE is discarded; both acks stay 0.
- Watchdog:
  - Counter runs in OWNx while the owner's enable is high.
  - Cleared on mem_ack_i, on release, and on grant.
  - When the count reaches TIMEOUT, timeout_o sets and stays set until reset.
  - The watchdog never affects the grant.

## Timing
- Reset values: state IDLE, `last` = 1 (port 0 wins the first tie), counter 0, grant_o = 00, timeout_o = 0. All mem_* outputs and acks are 0.
- Reset asserted mid-transaction aborts immediately; mem_enable_o drops asynchronously.
- Arbitration latency from IDLE is 1 cycle: enable rises in cycle N, grant_o and mem_enable_o are high in cycle N+1.
- Handover: the owner drops enable in cycle N, so mem_enable_o = 0 in cycle N. The other port owns memory in cycle N+1 with no extra bubble.
- Ack path is combinational, zero added latency. A requester must keep enable high until it has sampled its ack.
- A requester that is waiting sees no ack and simply stalls. No request is lost or reordered.
- Simultaneous release by the owner and a new request from the same port at one edge cannot occur; enable is a single level. A port that re-raises enable after release re-arbitrates normally.

## Test plan
- Single read from port 1:
  - Stimulus: m1_enable_i = 1, addr 0x0000_0400, memory acks 10 cycles later with data D.
  - Required: grant_o = 10 one cycle later; mem_addr_o = 0x400; m1_ack_o pulses with m1_data_o = D; m0_ack_o stays 0.
- Tie after reset:
  - Stimulus: both enables rise in the same cycle.
  - Required: port 0 granted first. After it releases, port 1 is granted on the next edge with mem_enable_o low for exactly one cycle.
- Sticky writeback then refill:
  - Stimulus: port 1 holds enable with write = 1 at 0x0000_8C20, acked, then write = 0 at 0x0000_0C20 with enable still high, while port 0 requests throughout.
  - Required: grant_o stays 10 through both acks; port 0 is granted only after port 1 drops enable.
- Fairness:
  - Stimulus: both ports request continuously, each releasing one cycle after its ack.
  - Required: grants alternate 01, 10, 01, 10.
- Watchdog:
  - Stimulus: TIMEOUT = 8, port 0 granted, no ack.
  - Required: timeout_o = 1 after 8 owned cycles; it stays 1 after a later ack; grant is unaffected.
- Reset mid-transaction:
  - Stimulus: assert rst_i low while OWN1.
  - Required: mem_enable_o = 0 and grant_o = 00 immediately. After reset release with both ports requesting, port 0 is granted first.
